// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and stream framing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    RX_WORD = 3'd3,
    WRITE   = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word assembler. full pulses alongside the shift that supplies the 4th byte,
// and word presents the completed value in that same cycle so the caller can register it.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        full
);

  logic [23:0] shift_r;
  logic [1:0]  count_r;

  // Shift bytes in MSB-first; the 2-bit counter wraps after the 4th byte to start the next word.
  always_ff @(posedge clock) begin
    if (rst) begin
      shift_r <= 24'd0;
      count_r <= 2'd0;
    end else if (clear) begin
      shift_r <= 24'd0;
      count_r <= 2'd0;
    end else if (shiftEn) begin
      shift_r <= {shift_r[15:0], byteIn};
      count_r <= count_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      count_r <= count_r;
    end
  end

  // Completed word and the completion strobe.
  always_comb begin
    word = {shift_r, byteIn};
    full = 1'b0;
    if (shiftEn && (count_r == 2'(BYTES_PER_WORD - 1))) begin
      full = 1'b1;
    end else begin
      full = 1'b0;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a 16-bit word-count header and writes big-endian words to instruction memory.
// Optional trailer XOR checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWrite,
  output logic [ADDR_BITS-1:0]  memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           wordCount
);

  state_t      state_r;
  logic [7:0]  len_hi_r;
  logic [15:0] n_r;
  logic [15:0] len_s;
  logic        xfer_s;
  logic        shift_en_s;
  logic        clear_s;
  logic [31:0] asm_word_s;
  logic        asm_full_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_r;
`endif

  // Handshake decode and assembler control.
  always_comb begin
    len_s      = {len_hi_r, byteIn};
    xfer_s     = byteValid && byteReady;
    shift_en_s = 1'b0;
    clear_s    = 1'b0;
    if ((state_r == RX_WORD) && xfer_s) begin
      shift_en_s = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
    if (start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR))) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  byte_assembler u_asm (
    .clock   (clock),
    .rst     (rst),
    .clear   (clear_s),
    .shiftEn (shift_en_s),
    .byteIn  (byteIn),
    .word    (asm_word_s),
    .full    (asm_full_s)
  );

  // Loader FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r   <= IDLE;
      len_hi_r  <= 8'd0;
      n_r       <= 16'd0;
      byteReady <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wordCount <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_r     <= 8'd0;
`endif
    end else begin
      memWrite <= 1'b0;
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_r   <= LEN_HI;
            byteReady <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            wordCount <= 16'd0;
            memAddr   <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_r     <= 8'd0;
`endif
          end
        end
        LEN_HI: begin
          if (xfer_s) begin
            len_hi_r <= byteIn;
            state_r  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer_s) begin
            n_r <= len_s;
            if (len_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_r   <= CHECK;
`else
              state_r   <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              byteReady <= 1'b0;
`endif
            end else if ({1'b0, len_s} > 17'(MEM_DEPTH)) begin
              // Oversized images are rejected before any write, so memAddr can never wrap.
              state_r   <= ERROR;
              error     <= 1'b1;
              busy      <= 1'b0;
              byteReady <= 1'b0;
            end else begin
              state_r <= RX_WORD;
            end
          end
        end
        RX_WORD: begin
          if (xfer_s) begin
`ifdef LOADER_CHECKSUM_EN
            xor_r <= xor_r ^ byteIn;
`endif
            if (asm_full_s) begin
              state_r   <= WRITE;
              byteReady <= 1'b0;
              memWrite  <= 1'b1;
              memData   <= DATA_WIDTH'(asm_word_s);
            end
          end
        end
        WRITE: begin
          wordCount <= wordCount + 16'd1;
          if ((wordCount + 16'd1) == n_r) begin
`ifdef LOADER_CHECKSUM_EN
            state_r   <= CHECK;
            byteReady <= 1'b1;
`else
            state_r   <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
`endif
          end else begin
            memAddr   <= memAddr + ADDR_BITS'(1);
            state_r   <= RX_WORD;
            byteReady <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer_s) begin
            byteReady <= 1'b0;
            busy      <= 1'b0;
            if (byteIn == xor_r) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= ERROR;
              error   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_r   <= IDLE;
          byteReady <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
